// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants, widths and window helper functions
package vga_timing_pkg;

    localparam int COORD_W = 10;
    localparam int COORD_MAX_TOTAL = 1 << COORD_W;

    localparam int ACTIVE_LOW  = 0;
    localparam int ACTIVE_HIGH = 1;

    // 640x480@60 with a 25.175 MHz pixel rate
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    function automatic int sync_start(input int visible, input int front);
        return visible + front;
    endfunction

    function automatic int sync_end(input int visible, input int front, input int sync);
        return visible + front + sync;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping position counter with visible and sync window decode
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int VISIBLE    = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               adv,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               visible,
    output logic               in_sync
);

    logic [COORD_W-1:0] count_q, count_d;
    logic               last;

    always_comb begin
        last    = (count_q == COORD_W'(TOTAL - 1));
        wrap    = adv && last;
        count_d = count_q;
        if (adv) begin
            count_d = last ? '0 : count_q + 1'b1;
        end
    end

    // One extra bit so window bounds equal to 2**COORD_W still compare correctly
    assign visible = ({1'b0, count_q} < (COORD_W + 1)'(VISIBLE));
    assign in_sync = ({1'b0, count_q} >= (COORD_W + 1)'(SYNC_START)) &&
                     ({1'b0, count_q} <  (COORD_W + 1)'(SYNC_END));
    assign count   = count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster sequencer; optional VGA_TIMING_FRAME_CNT_EN adds frame_cnt
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int HSYNC_POL = ACTIVE_LOW,
    parameter int VSYNC_POL = ACTIVE_LOW,
    parameter int CLK_DIV   = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ena,
    output logic               pix_tick,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [7:0]         frame_cnt,
`endif
    output logic               vblank
);

    localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic HS_ACT = (HSYNC_POL != 0);
    localparam logic VS_ACT = (VSYNC_POL != 0);

    if (H_TOTAL > COORD_MAX_TOTAL || V_TOTAL > COORD_MAX_TOTAL) begin : g_total_check
        $error("vga_timing_ctrl: H_TOTAL/V_TOTAL exceed 1024");
    end
    if (CLK_DIV < 1) begin : g_div_check
        $error("vga_timing_ctrl: CLK_DIV must be >= 1");
    end

    logic [DIV_W-1:0]   div_q, div_d;
    logic               tick;
    logic [COORD_W-1:0] h_count, v_count;
    logic               h_wrap, v_wrap, h_vis, v_vis, h_in_sync, v_in_sync;

    logic               pix_tick_q, pix_tick_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic               vblank_q, vblank_d;
    // Set when the next tick will present the frame origin (after reset or a frame wrap)
    logic               at_origin_q, at_origin_d;

    always_comb begin
        tick  = ena && (div_q == DIV_W'(CLK_DIV - 1));
        div_d = div_q;
        if (ena) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
    end

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (sync_start(H_VISIBLE, H_FRONT)),
        .SYNC_END   (sync_end(H_VISIBLE, H_FRONT, H_SYNC))
    ) u_h_counter (
        .clock   (clock),
        .reset   (reset),
        .adv     (tick),
        .count   (h_count),
        .wrap    (h_wrap),
        .visible (h_vis),
        .in_sync (h_in_sync)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (sync_start(V_VISIBLE, V_FRONT)),
        .SYNC_END   (sync_end(V_VISIBLE, V_FRONT, V_SYNC))
    ) u_v_counter (
        .clock   (clock),
        .reset   (reset),
        .adv     (h_wrap),
        .count   (v_count),
        .wrap    (v_wrap),
        .visible (v_vis),
        .in_sync (v_in_sync)
    );

    always_comb begin
        pix_tick_d    = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        vblank_d      = vblank_q;
        at_origin_d   = at_origin_q;
        if (tick) begin
            pix_tick_d    = 1'b1;
            x_d           = h_count;
            y_d           = v_count;
            de_d          = h_vis && v_vis;
            hsync_d       = h_in_sync ? HS_ACT : ~HS_ACT;
            vsync_d       = v_in_sync ? VS_ACT : ~VS_ACT;
            vblank_d      = ~v_vis;
            line_start_d  = (h_count == '0);
            frame_start_d = at_origin_q;
            at_origin_d   = v_wrap;
        end else if (!ena) begin
            de_d    = 1'b0;
            hsync_d = ~HS_ACT;
            vsync_d = ~VS_ACT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q         <= '0;
            pix_tick_q    <= 1'b0;
            hsync_q       <= ~HS_ACT;
            vsync_q       <= ~VS_ACT;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
            at_origin_q   <= 1'b1;
        end else begin
            div_q         <= div_d;
            pix_tick_q    <= pix_tick_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            vblank_q      <= vblank_d;
            at_origin_q   <= at_origin_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign pix_tick    = pix_tick_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign vblank      = vblank_q;

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Programmable VGA raster sequencer that paces the pixel datapath behind the top-level chip wrapper. It divides the system clock into pixel ticks and runs horizontal and vertical position counters. From those counters it produces sync, display-enable, pixel coordinates and line/frame strobes. Pixel generators and the output pin mux consume these outputs to know when and where to drive colour.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (ticks)
H_SYNC, 96, horizontal sync width (ticks)
H_BACK, 48, horizontal back porch (ticks)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync
CLK_DIV, 1, system clocks per pixel tick (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
ena  in  1  run enable (tile enable)
pix_tick  out  1  one-clock pulse when outputs advance to a new pixel
hsync  out  1  horizontal sync, polarity per HSYNC_POL
vsync  out  1  vertical sync, polarity per VSYNC_POL
de  out  1  display enable, 1 inside visible area
x  out  10  current horizontal position, 0..H_TOTAL-1
y  out  10  current vertical position, 0..V_TOTAL-1
line_start  out  1  pulse with the tick presenting x=0
frame_start  out  1  pulse with the tick presenting x=0, y=0
vblank  out  1  1 while y >= V_VISIBLE

Behaviour:
- Interface: single clock `clock`; `reset` is synchronous and active-high.
- Derived totals:
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK; V_TOTAL is the vertical equivalent.
  - Both totals must be <= 1024; elaboration error otherwise.
- All outputs are registered, so there is no combinational path from inputs.
- Reset values:
  - x=0, y=0, de=0, vblank=0.
  - hsync and vsync at their inactive level.
  - pix_tick, line_start and frame_start = 0.
  - Divider and internal counters = 0.
- Divider counts 0..CLK_DIV-1 while ena=1. A tick fires when the divider equals CLK_DIV-1; with CLK_DIV=1 every enabled clock is a tick.
- First tick after reset release presents (0,0): de=1, line_start=1, frame_start=1.
- On each tick the outputs show the current position, and the internal position then advances:
  - h wraps H_TOTAL-1 -> 0 and increments v.
  - v wraps V_TOTAL-1 -> 0 only on the tick where h also wraps (last pixel of the frame). Both wraps happen on that one tick.
- Decode on each tick:
  - de = (x < H_VISIBLE) && (y < V_VISIBLE).
  - hsync active for H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC.
  - vsync active for V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC, for the full line width.
- Outputs hold between ticks. The pulses (pix_tick, line_start, frame_start) are exactly one clock wide.
- ena=0:
  - Divider and position freeze; pulses stay 0.
  - de is forced 0 and hsync/vsync go inactive on the next clock. x, y and vblank hold.
  - When ena returns to 1, the first tick presents the position after the frozen one; no pixel is repeated.
- Reset asserted mid-frame: all state returns to reset values on that clock, regardless of ena.

Optional Feature:
VGA_TIMING_FRAME_CNT_EN
- Defined: adds output port frame_cnt (8 bits, reset 0). It increments on the clock that frame_start pulses and wraps 255 -> 0. The first frame_start after reset gives 1.
- Undefined: the port and its register do not exist; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - COORD_W = 10.
  - 640x480@60 default timing constants.
  - Functions deriving H_TOTAL/V_TOTAL and sync window bounds.
  - Polarity constants ACTIVE_LOW/ACTIVE_HIGH.
- Sub-module vga_axis_counter: generic wrapping counter with an advance input, a wrap output and visible/sync window decode. It is instantiated twice: h advances on tick, v advances on h wrap.

Test Plan:
- Reset held 3 clocks, then released with ena=1, CLK_DIV=1 -> during reset all outputs at reset values. Next clock: x=0, y=0, de=1, line_start=1, frame_start=1.
- Run one line -> hsync low exactly for x=656..751 (96 ticks), de=0 for x>=640, x wraps 799 -> 0 with y 0 -> 1 and line_start=1.
- Run full frame -> vsync low only on lines 490-491, vblank=1 for y 480..524. After x=799, y=524 the next tick is (0,0) with frame_start=1; 420000 ticks per frame.
- ena dropped at x=100 for 7 clocks -> x holds 100, de=0, syncs inactive; after ena=1 the next tick shows x=101.
- CLK_DIV=2 -> pix_tick every second clock and x advances every 2 clocks. Reset pulsed at x=300, y=200 -> next state is reset values, then (0,0).
- With VGA_TIMING_FRAME_CNT_EN defined, run 256 frames -> frame_cnt 1, 2, ... 255, 0.
